// File: rtl/adi_tala_tracker.sv
// Adi tala tracker: detects onsets in the generator's beat-action stream, locks onto
// the 8-beat laghu/drutam/drutam pattern and reports position, sama, period and errors.
module adi_tala_tracker #(
  parameter int CYC_W   = 8,
  parameter int PER_W   = 16,
  parameter int TIMEOUT = 1024,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       beat_code,
  output logic             beat_pulse,
  output logic [2:0]       beat_idx,
  output logic [1:0]       anga,
  output logic             sama,
  output logic             locked,
  output logic [CYC_W-1:0] cycle_count,
  output logic [PER_W-1:0] beat_period,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {HUNT = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [PER_W-1:0] GAP_MAX = '1;
  localparam logic [PER_W-1:0] TO_LAST = PER_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state, state_nxt;
  logic [2:0]       pos, pos_nxt;
  logic [1:0]       code_q;
  logic [PER_W-1:0] gap;
  logic             first_onset;
  logic             onset, match, timeout;
  logic [2:0]       exp_idx;
  logic             do_lock, do_adv, do_err;

  // Expected action per beat: clap on 0/4/6, finger count on 1-3, wave on 5/7.
  function automatic logic [1:0] pat(input logic [2:0] i);
    case (i)
      3'd0, 3'd4, 3'd6: pat = 2'b01;
      3'd5, 3'd7:       pat = 2'b11;
      default:          pat = 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] anga_of(input logic [2:0] i);
    anga_of = {i[2] & i[1], i[2] & ~i[1]};
  endfunction

  always_comb begin
    onset   = (beat_code != 2'b00) && (code_q == 2'b00);
    exp_idx = ((state == LOCKED) ? beat_idx : pos) + 3'd1;
    match   = (beat_code == pat(exp_idx));
    // An onset clears the gap counter, so it always beats a coincident timeout.
    timeout = !onset && (state != HUNT) && (gap == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      pos   <= 3'd0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    do_lock   = 1'b0;
    do_adv    = 1'b0;
    do_err    = 1'b0;
    case (state)
      HUNT: begin
        if (onset && beat_code == 2'b01) begin
          state_nxt = ALIGN;
          pos_nxt   = 3'd0;
        end
      end
      ALIGN: begin
        if (onset) begin
          if (match) begin
            if (pos == 3'd7) begin
              state_nxt = LOCKED;
              do_lock   = 1'b1;
            end else begin
              pos_nxt = pos + 3'd1;
            end
          end else if (beat_code == 2'b01) begin
            pos_nxt = 3'd0;
          end else begin
            state_nxt = HUNT;
          end
        end else if (timeout) begin
          state_nxt = HUNT;
        end
      end
      LOCKED: begin
        if (onset) begin
          if (match) begin
            do_adv = 1'b1;
          end else begin
            do_err    = 1'b1;
            state_nxt = HUNT;
          end
        end else if (timeout) begin
          do_err    = 1'b1;
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= 2'b00;
      gap         <= '0;
      first_onset <= 1'b1;
      beat_pulse  <= 1'b0;
      sama        <= 1'b0;
      err_pulse   <= 1'b0;
      beat_idx    <= 3'd0;
      anga        <= 2'b00;
      cycle_count <= '0;
      beat_period <= '0;
      err_count   <= '0;
    end else begin
      code_q     <= beat_code;
      beat_pulse <= onset;
      sama       <= do_lock | (do_adv & (beat_idx == 3'd7));
      err_pulse  <= do_err;

      if (onset) begin
        gap         <= '0;
        first_onset <= 1'b0;
        if (!first_onset)
          beat_period <= (gap == GAP_MAX) ? GAP_MAX : gap + PER_W'(1);
      end else if (gap != GAP_MAX) begin
        gap <= gap + PER_W'(1);
      end

      if (do_lock) begin
        beat_idx    <= 3'd0;
        anga        <= 2'b00;
        cycle_count <= cycle_count + CYC_W'(1);
      end else if (do_adv) begin
        beat_idx <= beat_idx + 3'd1;
        anga     <= anga_of(beat_idx + 3'd1);
        if (beat_idx == 3'd7)
          cycle_count <= cycle_count + CYC_W'(1);
      end

      if (do_err && err_count != ERR_MAX)
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_adi_tala_tracker.sv
// Bench for adi_tala_tracker: directed scenarios plus random beat streams, checked
// every cycle against a behavioural model of the tala rules.
module tb_adi_tala_tracker;
  localparam int CYC_W   = 8;
  localparam int PER_W   = 16;
  localparam int TIMEOUT = 1024;
  localparam int ERR_W   = 8;
  localparam int PMAX    = (1 << PER_W) - 1;
  localparam int EMAX    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       beat_code;
  logic             beat_pulse, sama, locked, err_pulse;
  logic [2:0]       beat_idx;
  logic [1:0]       anga;
  logic [CYC_W-1:0] cycle_count;
  logic [PER_W-1:0] beat_period;
  logic [ERR_W-1:0] err_count;

  adi_tala_tracker #(.CYC_W(CYC_W), .PER_W(PER_W), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .beat_code(beat_code), .beat_pulse(beat_pulse),
    .beat_idx(beat_idx), .anga(anga), .sama(sama), .locked(locked),
    .cycle_count(cycle_count), .beat_period(beat_period), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int P [8] = '{1, 2, 2, 2, 1, 3, 1, 3};
  int checks = 0;
  int errors = 0;
  int sama_seen = 0, err_seen = 0, pulse_seen = 0;

  // Model: mode 0 hunt, 1 aligning (pos = beats matched so far), 2 locked.
  int m_mode, m_pos, m_idx, m_prev, m_gap, m_cyc, m_per, m_errc;
  bit m_first, m_pulse, m_sama, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pos <= 0; m_idx <= 0; m_prev <= 0; m_gap <= 0;
      m_cyc <= 0; m_per <= 0; m_errc <= 0; m_first <= 1'b1;
      m_pulse <= 1'b0; m_sama <= 1'b0; m_err <= 1'b0;
    end else begin : step
      int c, g, md, ps, ix, cc, ec, per;
      bit on, first, sa, er;
      c = int'(beat_code);
      on = (c != 0) && (m_prev == 0);
      g = m_gap; md = m_mode; ps = m_pos; ix = m_idx;
      cc = m_cyc; ec = m_errc; per = m_per; first = m_first;
      sa = 0; er = 0;
      if (on) begin
        if (!first) per = (g + 1 > PMAX) ? PMAX : g + 1;
        first = 0;
        if (md == 0) begin
          if (c == 1) begin md = 1; ps = 0; end
        end else if (md == 1) begin
          if (c == P[(ps + 1) % 8]) begin
            if (ps == 7) begin md = 2; ix = 0; sa = 1; cc = (cc + 1) % 256; end
            else ps = ps + 1;
          end else if (c == 1) ps = 0;
          else md = 0;
        end else begin
          if (c == P[(ix + 1) % 8]) begin
            ix = (ix + 1) % 8;
            if (ix == 0) begin sa = 1; cc = (cc + 1) % 256; end
          end else begin
            er = 1; md = 0;
          end
        end
      end else if (md != 0 && g + 1 >= TIMEOUT) begin
        if (md == 2) er = 1;
        md = 0;
      end
      if (er && ec < EMAX) ec = ec + 1;
      g = on ? 0 : ((g < PMAX) ? g + 1 : PMAX);
      m_mode <= md; m_pos <= ps; m_idx <= ix; m_prev <= c; m_gap <= g;
      m_cyc <= cc; m_per <= per; m_errc <= ec; m_first <= first;
      m_pulse <= on; m_sama <= sa; m_err <= er;
    end
  end

  always @(negedge clk) begin
    chk("beat_pulse", beat_pulse, m_pulse);
    chk("sama", sama, m_sama);
    chk("err_pulse", err_pulse, m_err);
    chk("locked", locked, (m_mode == 2));
    chk("beat_idx", beat_idx, m_idx);
    chk("anga", anga, (m_idx < 4) ? 0 : ((m_idx < 6) ? 1 : 2));
    chk("cycle_count", cycle_count, m_cyc);
    chk("beat_period", beat_period, m_per);
    chk("err_count", err_count, m_errc);
    if (sama) sama_seen++;
    if (err_pulse) err_seen++;
    if (beat_pulse) pulse_seen++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input int c, input int on, input int off);
    beat_code = 2'(c);
    tick(on);
    beat_code = 2'b00;
    tick(off);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_pulse"}, beat_pulse, 0);
    chk({tag, "_idx"}, beat_idx, 0);
    chk({tag, "_anga"}, anga, 0);
    chk({tag, "_sama"}, sama, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_cyc"}, cycle_count, 0);
    chk({tag, "_per"}, beat_period, 0);
    chk({tag, "_err"}, err_pulse, 0);
    chk({tag, "_errc"}, err_count, 0);
  endtask

  initial begin
    int s, r, c;
    rst_n = 1'b0;
    beat_code = 2'b00;
    #3;
    outputs_zero("reset");
    tick(2);
    rst_n = 1'b1;

    // Clean stream from sama: lock on the 9th onset, two cycles counted.
    sama_seen = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 8) chk("pre_lock", locked, 0);
      beat_code = 2'(P[k % 8]);
      tick(1);
      if (k == 8) begin
        chk("lock_9th", locked, 1);
        chk("sama_9th", sama, 1);
      end
      tick(3);
      beat_code = 2'b00;
      tick(4);
    end
    chk("clean_cyc", cycle_count, 2);
    chk("clean_per", beat_period, 8);
    chk("clean_errc", err_count, 0);
    chk("clean_sama_cnt", sama_seen, 2);

    // Mid-cycle start at beat 4: false aligns on beats 4 and 6, lock at next sama.
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    for (int k = 4; k < 16; k++) beat(P[k % 8], 4, 4);
    chk("mid_not_locked", locked, 0);
    beat(P[0], 4, 4);
    chk("mid_locked", locked, 1);
    chk("mid_errc", err_count, 0);
    chk("mid_cyc", cycle_count, 1);

    // Corrupt beat 6 while locked, then relock after a clean cycle.
    err_seen = 0;
    for (int k = 1; k < 6; k++) beat(P[k], 4, 4);
    beat(2, 4, 4);
    chk("bad6_err_once", err_seen, 1);
    chk("bad6_errc", err_count, 1);
    chk("bad6_unlocked", locked, 0);
    beat(P[7], 4, 4);
    for (int k = 0; k < 8; k++) beat(P[k], 4, 4);
    beat_code = 2'b01;
    tick(1);
    chk("relock", locked, 1);
    chk("relock_cyc", cycle_count, 2);

    // Silence after the sama clap: timeout on the TIMEOUT-th idle edge.
    beat_code = 2'b00;
    tick(TIMEOUT - 1);
    chk("to_still_locked", locked, 1);
    tick(1);
    chk("to_unlocked", locked, 0);
    chk("to_err_pulse", err_pulse, 1);
    chk("to_errc", err_count, 2);

    // Code change without an idle gap is a single onset.
    pulse_seen = 0;
    beat_code = 2'b01; tick(3);
    beat_code = 2'b10; tick(3);
    beat_code = 2'b00; tick(3);
    chk("nogap_pulses", pulse_seen, 1);
    for (int k = 1; k < 8; k++) beat(P[k], 3, 3);
    beat(P[0], 3, 3);
    chk("nogap_relock", locked, 1);
    chk("nogap_cyc", cycle_count, 3);

    // Asynchronous reset mid-beat while locked; held clap is an onset after release.
    beat_code = 2'b10;
    tick(2);
    #2 rst_n = 1'b0;
    #1 outputs_zero("async");
    beat_code = 2'b01;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_pulse", beat_pulse, 1);
    chk("post_rst_locked", locked, 0);
    beat_code = 2'b00;
    tick(3);
    for (int k = 1; k < 8; k++) beat(P[k], 2, 2);
    beat(P[0], 2, 2);
    chk("post_rst_lock", locked, 1);
    chk("post_rst_cyc", cycle_count, 1);

    // Random streams: mostly pattern-correct, with stray codes, no-gap changes, long idles.
    s = 1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 199);
      if (r < 160) begin
        c = P[s % 8];
        s++;
      end else begin
        c = $urandom_range(1, 3);
      end
      if (r == 199) beat(c, 2, TIMEOUT + 20);
      else beat(c, $urandom_range(1, 5), $urandom_range(0, 4));
    end
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adi_tala_tracker.md
Name: adi_tala_tracker

Overview:
- Downstream consumer of the adi tala generator's 2-bit beat-action output.
- Detects beat onsets and locks onto the 8-beat Adi tala pattern (laghu 4 + drutam 2 + drutam 2).
- Reports beat position, anga, sama (beat 1) pulses, completed-cycle count, beat period and pattern errors.
- Feeds display and monitor logic.

Parameters:
- CYC_W, 8, width of completed-cycle (avartanam) counter; wraps modulo 2^CYC_W.
- PER_W, 16, width of beat-period measurement; saturates at 2^PER_W-1.
- TIMEOUT, 1024, cycles without an onset before ALIGN/LOCKED abandons lock.
- ERR_W, 8, width of error counter; saturates.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- beat_code  in  2  generator action code: 00 idle/gap, 01 clap, 10 finger count, 11 wave
- beat_pulse  out  1  one-cycle strobe per detected onset
- beat_idx  out  3  position 0..7 in cycle (valid when locked)
- anga  out  2  00 laghu (idx 0-3), 01 drutam1 (4-5), 10 drutam2 (6-7)
- sama  out  1  one-cycle strobe on idx-0 onset while locked
- locked  out  1  high in LOCKED
- cycle_count  out  CYC_W  completed cycles
- beat_period  out  PER_W  cycles between last two onsets
- err_pulse  out  1  one-cycle strobe on pattern mismatch or timeout while ALIGN/LOCKED
- err_count  out  ERR_W  total errors, saturating

Behaviour:
- Reset (async assert, sync release): all outputs 0, state HUNT, code_q=00, gap counter 0, first_onset flag set.
- Expected pattern P[0..7] = 01,10,10,10,01,11,01,11.
- Onset: beat_code!=00 and code_q==00. code_q registers beat_code every cycle. A code change without an intervening 00 is not an onset.
- All outputs are registered. Strobes are high the cycle after the edge at which the onset was sampled. Latency is 1 cycle.
- Gap counter:
  - Counts cycles since last onset, saturating.
  - At each onset, beat_period <= counter+1 (saturating) and counter clears.
  - The first onset after reset does not update beat_period.
- States:
  - HUNT: onset with code 01 -> ALIGN, pos=0. Other onsets are ignored. No errors are counted.
  - ALIGN: each onset is compared with P[(pos+1) mod 8].
    - Match with pos<7: pos++.
    - Match with pos==7 (the onset is a clap at sama): -> LOCKED, beat_idx=0, sama=1, cycle_count++.
    - Mismatch where the onset is 01: stay ALIGN, pos=0.
    - Other mismatch: -> HUNT.
    - ALIGN mismatches do not raise err_pulse.
  - LOCKED: each onset is compared with P[(beat_idx+1) mod 8].
    - Match: beat_idx advances, anga updates, beat_pulse=1. sama=1 and cycle_count++ when the new idx is 0.
    - Mismatch: err_pulse=1, err_count++, locked=0, -> HUNT.
    - A mismatching onset coded 01 does NOT re-enter ALIGN on the same cycle.
- Timeout: gap counter reaches TIMEOUT in ALIGN or LOCKED -> HUNT, locked=0. In LOCKED only, also err_pulse=1 and err_count++.
- beat_pulse fires on every onset in any state, HUNT included.
- beat_idx and anga hold their last value when not locked.
- Onset and timeout on the same cycle: the onset wins, because the counter clears.
- cycle_count wraps. err_count and beat_period saturate.
- Reset mid-cycle: immediate return to reset values. The held beat_code is treated as an onset on the first post-reset edge.
- Beat_code persistently nonzero: no further onsets, so timeout eventually applies.

Test Plan:
- Clean stream, each beat 4 cycles code + 4 cycles 00, two full cycles starting at sama:
  - locked rises 1 cycle after the 9th onset.
  - sama strobes at onsets 9 and 17.
  - cycle_count=2.
  - beat_period=8.
  - err_count=0.
- Start mid-cycle at beat 4 (clap 01, then 11,01,11,01,...):
  - Tracker falsely aligns on the claps at beats 4 and 6, then rejects them.
  - It locks only after the sama clap following a full 8-beat match.
  - err_count stays 0.
- While locked, replace beat 6 (expected 01) with 10:
  - err_pulse once, err_count=1, locked=0.
  - Relock after the next clean full cycle.
- While locked, hold beat_code=00 for TIMEOUT cycles:
  - err_pulse at the TIMEOUT-th idle cycle, locked=0, state HUNT.
- Codes 01->10 with no 00 gap:
  - Only one beat_pulse; the second code is not an onset.
- Assert rst_n low mid-cycle while locked:
  - All outputs 0 asynchronously.
  - After release with beat_code=01 held, beat_pulse on the first edge and state ALIGN.
